iob_bus_merge2: RTL and testbench
=================================

IOB_BUS_MERGE2 -- requirements
Module: iob_bus_merge2

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32, data width; wstrb width is DATA_W/8.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cke_i  input  1  clock enable; when 0, all registers hold.
REQ-006 SHALL have ports m0_valid_i, m1_valid_i  input  1  request valid; m0 = CPU instruction bus, m1 = CPU data bus.
REQ-007 SHALL have ports m0_addr_i, m1_addr_i  input  ADDR_W  request address.
REQ-008 SHALL have ports m0_wdata_i, m1_wdata_i  input  DATA_W  write data.
REQ-009 SHALL have ports m0_wstrb_i, m1_wstrb_i  input  DATA_W/8  byte strobes; all-zero means read.
REQ-010 SHALL have ports m0_rdata_o, m1_rdata_o  output  DATA_W  read data.
REQ-011 SHALL have ports m0_rvalid_o, m1_rvalid_o  output  1  read data valid, one-cycle pulse.
REQ-012 SHALL have ports m0_ready_o, m1_ready_o  output  1  request accepted this cycle.
REQ-013 SHALL have ports s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o  output  1/ADDR_W/DATA_W/DATA_W/8  merged request to memory.
REQ-014 SHALL have ports s_rdata_i, s_rvalid_i, s_ready_i  input  DATA_W/1/1  memory response.
REQ-015 SHALL have port err_o  output  1  sticky: s_rvalid_i received with no read outstanding.

Function
REQ-016 A request SHALL transfer on any cycle where valid and ready are both 1 on the same port; valid may be a single-cycle pulse.
REQ-017 FSM states SHALL be IDLE and WAIT_RD; at most one read outstanding; writes produce no response.
REQ-018 In IDLE, grant SHALL be combinational: only one master valid -> that master; both valid -> master not granted at last contention (register last_m, reset 1, so m0 wins first contention).
REQ-019 last_m SHALL update only on a cycle where both masters are valid and s_ready_i=1.
REQ-020 In IDLE, s_valid_o/s_addr_o/s_wdata_o/s_wstrb_o SHALL equal the granted master's fields; with no grant, s_valid_o=0 and remaining s_* outputs are 0.
REQ-021 Granted master's ready_o SHALL equal s_ready_i; non-granted master's ready_o SHALL be 0.
REQ-022 Accepted read (wstrb==0) SHALL register owner=granted index and move to WAIT_RD next cycle; accepted write SHALL stay in IDLE and next request may issue the following cycle.
REQ-023 In WAIT_RD, s_valid_o SHALL be 0 and both m*_ready_o SHALL be 0, regardless of master valids.
REQ-024 In WAIT_RD, s_rvalid_i=1 SHALL drive owner's rvalid_o=1 and rdata_o=s_rdata_i in the same cycle (zero latency), and return to IDLE next cycle.
REQ-025 Non-owner rdata_o SHALL be 0 and rvalid_o 0 at all times; rdata_o of both masters SHALL be 0 when not rvalid.
REQ-026 s_rvalid_i=1 in IDLE SHALL be dropped (no m*_rvalid_o) and set err_o=1 next cycle; err_o clears only on reset.
REQ-027 Read latency through block: request path 0 cycles, response path 0 cycles; a new request can issue the cycle after rvalid at earliest.
REQ-028 With cke_i=0, state, owner, last_m and err_o SHALL hold; combinational paths remain active.

Reset
REQ-029 rst_i=1 on a clock edge SHALL set state=IDLE, owner=0, last_m=1, err_o=0; all outputs then follow IDLE rules (all m*_ready_o follow REQ-021, rvalid/rdata 0).
REQ-030 Reset during WAIT_RD SHALL abandon the read; a late s_rvalid_i after reset SHALL set err_o per REQ-026.

Verification
REQ-031 m1 write addr 0x100 wstrb 0xF, s_ready_i=1 -> s_valid_o=1 same cycle, m1_ready_o=1, no rvalid, state stays IDLE.
REQ-032 m0 read addr 0x40, memory returns 0xDEADBEEF 2 cycles later -> m0_rvalid_o=1 with 0xDEADBEEF, m1_rvalid_o=0, m1_rdata_o=0.
REQ-033 m0 and m1 valid together thrice (writes, s_ready_i=1) -> grants m0, m1, m0.
REQ-034 m1 valid during WAIT_RD for m0 -> s_valid_o=0, m1_ready_o=0 until cycle after m0 rvalid, then m1 granted.
REQ-035 s_rvalid_i=1 in IDLE -> no master rvalid, err_o=1 next cycle and held until rst_i.
REQ-036 rst_i asserted in WAIT_RD, then s_rvalid_i -> state IDLE after reset, response dropped, err_o=1.

Source files
------------

// File: rtl/iob_bus_merge2.sv
// Two-master to one-slave bus merger: round-robin arbitration on contention,
// at most one read outstanding, zero-latency request and response paths.
module iob_bus_merge2 #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cke_i,

  input  logic                m0_valid_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic [DATA_W-1:0]   m0_rdata_o,
  output logic                m0_rvalid_o,
  output logic                m0_ready_o,

  input  logic                m1_valid_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                m1_rvalid_o,
  output logic                m1_ready_o,

  output logic                s_valid_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic                s_rvalid_i,
  input  logic                s_ready_i,

  output logic                err_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_RD = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   last_m, last_m_nxt;
  logic   err_nxt;
  logic   gnt_vld, gnt;
  logic   both_vld;

  // State register; reset wins over the clock enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last_m <= 1'b1;
      err_o  <= 1'b0;
    end else if (cke_i) begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      last_m <= last_m_nxt;
      err_o  <= err_nxt;
    end
  end

  // Arbitration, request routing and response steering.
  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    last_m_nxt  = last_m;
    err_nxt     = err_o;
    both_vld    = m0_valid_i & m1_valid_i;
    gnt_vld     = 1'b0;
    gnt         = 1'b0;
    s_valid_o   = 1'b0;
    s_addr_o    = '0;
    s_wdata_o   = '0;
    s_wstrb_o   = '0;
    m0_ready_o  = 1'b0;
    m1_ready_o  = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;

    case (state)
      IDLE: begin
        gnt_vld = m0_valid_i | m1_valid_i;
        // Contention goes to whoever did not win last time.
        gnt     = both_vld ? ~last_m : m1_valid_i;
        if (gnt_vld) begin
          s_valid_o  = 1'b1;
          s_addr_o   = gnt ? m1_addr_i  : m0_addr_i;
          s_wdata_o  = gnt ? m1_wdata_i : m0_wdata_i;
          s_wstrb_o  = gnt ? m1_wstrb_i : m0_wstrb_i;
          m0_ready_o = ~gnt & s_ready_i;
          m1_ready_o = gnt & s_ready_i;
          if (s_ready_i) begin
            if (both_vld) last_m_nxt = gnt;
            if (s_wstrb_o == STRB_W'(0)) begin
              state_nxt = WAIT_RD;
              owner_nxt = gnt;
            end
          end
        end
        // A response with no read outstanding is dropped and flagged.
        if (s_rvalid_i) err_nxt = 1'b1;
      end
      WAIT_RD: begin
        if (s_rvalid_i) begin
          m0_rvalid_o = ~owner;
          m1_rvalid_o = owner;
          m0_rdata_o  = owner ? '0 : s_rdata_i;
          m1_rdata_o  = owner ? s_rdata_i : '0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iob_bus_merge2.sv
// Randomized and directed checks of iob_bus_merge2 against a transaction-level model.
module tb_iob_bus_merge2;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic clk = 1'b0, rst_i, cke_i;
  logic m0_valid_i, m1_valid_i;
  logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
  logic [DATA_W-1:0] m0_wdata_i, m1_wdata_i;
  logic [STRB_W-1:0] m0_wstrb_i, m1_wstrb_i;
  logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o;
  logic m0_rvalid_o, m1_rvalid_o, m0_ready_o, m1_ready_o;
  logic s_valid_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [DATA_W-1:0] s_wdata_o;
  logic [STRB_W-1:0] s_wstrb_o;
  logic [DATA_W-1:0] s_rdata_i;
  logic s_rvalid_i, s_ready_i;
  logic err_o;

  int errors = 0;
  int checks = 0;

  // Model: which master (if any) awaits read data, who last won contention, error flag.
  int  pend_rd   = -1;
  int  last_win  = 1;
  bit  err_model = 1'b0;

  always #5 clk = ~clk;

  iob_bus_merge2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .cke_i(cke_i),
    .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_wstrb_i(m0_wstrb_i), .m0_rdata_o(m0_rdata_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_ready_o(m0_ready_o),
    .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_wstrb_i(m1_wstrb_i), .m1_rdata_o(m1_rdata_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_ready_o(m1_ready_o),
    .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_wstrb_o(s_wstrb_o), .s_rdata_i(s_rdata_i), .s_rvalid_i(s_rvalid_i),
    .s_ready_i(s_ready_i), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Which master the model grants this cycle (-1 = none).
  function automatic int model_grant();
    if (pend_rd >= 0) return -1;
    if (m0_valid_i && m1_valid_i) return (last_win == 0) ? 1 : 0;
    if (m0_valid_i) return 0;
    if (m1_valid_i) return 1;
    return -1;
  endfunction

  // Sample all outputs mid-cycle and compare with the model.
  task automatic sample();
    int g;
    @(negedge clk);
    g = model_grant();
    check("s_valid",  64'(s_valid_o), 64'(g >= 0));
    check("s_addr",   64'(s_addr_o),  g == 0 ? 64'(m0_addr_i)  : g == 1 ? 64'(m1_addr_i)  : 64'd0);
    check("s_wdata",  64'(s_wdata_o), g == 0 ? 64'(m0_wdata_i) : g == 1 ? 64'(m1_wdata_i) : 64'd0);
    check("s_wstrb",  64'(s_wstrb_o), g == 0 ? 64'(m0_wstrb_i) : g == 1 ? 64'(m1_wstrb_i) : 64'd0);
    check("m0_ready", 64'(m0_ready_o), 64'(g == 0 && s_ready_i));
    check("m1_ready", 64'(m1_ready_o), 64'(g == 1 && s_ready_i));
    check("m0_rvalid", 64'(m0_rvalid_o), 64'(pend_rd == 0 && s_rvalid_i));
    check("m1_rvalid", 64'(m1_rvalid_o), 64'(pend_rd == 1 && s_rvalid_i));
    check("m0_rdata", 64'(m0_rdata_o), (pend_rd == 0 && s_rvalid_i) ? 64'(s_rdata_i) : 64'd0);
    check("m1_rdata", 64'(m1_rdata_o), (pend_rd == 1 && s_rvalid_i) ? 64'(s_rdata_i) : 64'd0);
    check("err", 64'(err_o), 64'(err_model));
  endtask

  // Apply the clock edge to the model, then move to the next drive point.
  task automatic advance();
    int g;
    g = model_grant();
    if (rst_i) begin
      pend_rd = -1; last_win = 1; err_model = 1'b0;
    end else if (cke_i) begin
      if (pend_rd >= 0) begin
        if (s_rvalid_i) pend_rd = -1;
      end else begin
        if (s_rvalid_i) err_model = 1'b1;
        if (g >= 0 && s_ready_i) begin
          if (m0_valid_i && m1_valid_i) last_win = g;
          if ((g == 0 ? m0_wstrb_i : m1_wstrb_i) == '0) pend_rd = g;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst_i = 1'b0; cke_i = 1'b1; s_ready_i = 1'b1; s_rvalid_i = 1'b0; s_rdata_i = '0;
    m0_valid_i = 1'b0; m0_addr_i = '0; m0_wdata_i = '0; m0_wstrb_i = '0;
    m1_valid_i = 1'b0; m1_addr_i = '0; m1_wdata_i = '0; m1_wstrb_i = '0;
  endtask

  task automatic do_reset();
    quiet();
    rst_i = 1'b1;
    sample(); advance();
    sample(); advance();
    rst_i = 1'b0;
  endtask

  initial begin
    quiet();
    rst_i = 1'b1;
    @(posedge clk); #1;
    advance();
    rst_i = 1'b0;
    sample();
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_s_valid", 64'(s_valid_o), 64'd0);
    advance();

    // m1 write, accepted the same cycle, no response, stays idle.
    m1_valid_i = 1'b1; m1_addr_i = 32'h100; m1_wdata_i = 32'h1234_5678; m1_wstrb_i = 4'hF;
    sample();
    check("wr_s_valid", 64'(s_valid_o), 64'd1);
    check("wr_m1_ready", 64'(m1_ready_o), 64'd1);
    check("wr_s_addr", 64'(s_addr_o), 64'h100);
    check("wr_rvalid", 64'({m0_rvalid_o, m1_rvalid_o}), 64'd0);
    advance();
    quiet();
    m0_valid_i = 1'b1; m0_addr_i = 32'h8; m0_wstrb_i = 4'h3;
    sample();
    check("wr_still_idle", 64'(m0_ready_o), 64'd1);
    advance();

    // m0 read, m1 blocked while waiting, data returns two cycles later.
    quiet();
    m0_valid_i = 1'b1; m0_addr_i = 32'h40;
    sample();
    check("rd_m0_ready", 64'(m0_ready_o), 64'd1);
    advance();
    quiet();
    m1_valid_i = 1'b1; m1_addr_i = 32'h200; m1_wstrb_i = 4'hF; m1_wdata_i = 32'hAA;
    sample();
    check("wait_s_valid", 64'(s_valid_o), 64'd0);
    check("wait_m1_ready", 64'(m1_ready_o), 64'd0);
    advance();
    s_rvalid_i = 1'b1; s_rdata_i = 32'hDEAD_BEEF;
    sample();
    check("rd_m0_rvalid", 64'(m0_rvalid_o), 64'd1);
    check("rd_m0_rdata", 64'(m0_rdata_o), 64'hDEAD_BEEF);
    check("rd_m1_rvalid", 64'(m1_rvalid_o), 64'd0);
    check("rd_m1_rdata", 64'(m1_rdata_o), 64'd0);
    check("rd_m1_blocked", 64'(m1_ready_o), 64'd0);
    advance();
    s_rvalid_i = 1'b0; s_rdata_i = '0;
    sample();
    check("after_rd_m1_ready", 64'(m1_ready_o), 64'd1);
    check("after_rd_s_addr", 64'(s_addr_o), 64'h200);
    advance();

    // Three contended writes alternate m0, m1, m0.
    quiet();
    m0_valid_i = 1'b1; m0_addr_i = 32'h10; m0_wstrb_i = 4'h1;
    m1_valid_i = 1'b1; m1_addr_i = 32'h20; m1_wstrb_i = 4'h2;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("rr_m0_ready", 64'(m0_ready_o), 64'((i % 2) == 0));
      check("rr_m1_ready", 64'(m1_ready_o), 64'((i % 2) == 1));
      advance();
    end

    // Stray response in idle: dropped, sticky error.
    quiet();
    s_rvalid_i = 1'b1; s_rdata_i = 32'h5555_5555;
    sample();
    check("stray_rvalid", 64'({m0_rvalid_o, m1_rvalid_o}), 64'd0);
    advance();
    s_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("stray_err_sticky", 64'(err_o), 64'd1);
      advance();
    end

    // Reset in the middle of a read, then a late response.
    do_reset();
    m1_valid_i = 1'b1; m1_addr_i = 32'h44;
    sample(); advance();
    quiet();
    rst_i = 1'b1;
    sample(); advance();
    rst_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h1111_2222;
    sample();
    check("late_rvalid", 64'({m0_rvalid_o, m1_rvalid_o}), 64'd0);
    advance();
    s_rvalid_i = 1'b0;
    sample();
    check("late_err", 64'(err_o), 64'd1);
    advance();

    // Randomized traffic, including clock-enable stalls and occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_i      = ($urandom_range(199) == 0);
      cke_i      = ($urandom_range(7) != 0);
      s_ready_i  = ($urandom_range(3) != 0);
      m0_valid_i = $urandom_range(1);
      m1_valid_i = $urandom_range(1);
      m0_addr_i  = $urandom; m1_addr_i = $urandom;
      m0_wdata_i = $urandom; m1_wdata_i = $urandom;
      m0_wstrb_i = $urandom_range(1) ? 4'h0 : STRB_W'($urandom);
      m1_wstrb_i = $urandom_range(1) ? 4'h0 : STRB_W'($urandom);
      s_rvalid_i = (pend_rd >= 0) ? ($urandom_range(2) == 0) : ($urandom_range(99) == 0);
      s_rdata_i  = $urandom;
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
